demorgan_sweep_checker: RTL and testbench

Self-sequencing equivalence checker for the lab's gate experiments. On a start request it sweeps every operand pair (a, b) of WIDTH bits through two paths: a bitwise reference gate, and the same function built only from NAND or only from NOR cells. It counts mismatches and records the first failing pair. It is the clocked, parametrised successor of the hand-stepped two-input De Morgan and universal-gate checks, and sits beside the experiment benches as a reusable checker.

---
 rtl/demorgan_pkg.sv | 22 ++
 rtl/universal_gate_net.sv | 46 ++++
 rtl/demorgan_sweep_checker.sv | 164 ++++++++++++++++
 tb/tb_demorgan_sweep_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/demorgan_pkg.sv
// Shared types for the De Morgan / universal-gate sweep checker.
package demorgan_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_NAND = 2'd2,
        OP_NOR  = 2'd3
    } op_e;

    typedef enum logic {
        STY_NAND = 1'b0,
        STY_NOR  = 1'b1
    } style_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/universal_gate_net.sv
// AND/OR/NAND/NOR built bitwise from nand-only and nor-only primitive networks.
// Only the final op/style selection is behavioural; it is not part of the networks under test.
module universal_gate_net
    import demorgan_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  style_e           style,
    output logic [WIDTH-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            wire nd_nand, nd_and, nd_na, nd_nb, nd_or, nd_nor;
            wire nr_nor, nr_or, nr_na, nr_nb, nr_and, nr_nand;
            wire nd_y, nr_y;

            nand u_nd_nand (nd_nand, a[gi], b[gi]);
            nand u_nd_and  (nd_and, nd_nand, nd_nand);
            nand u_nd_na   (nd_na, a[gi], a[gi]);
            nand u_nd_nb   (nd_nb, b[gi], b[gi]);
            nand u_nd_or   (nd_or, nd_na, nd_nb);
            nand u_nd_nor  (nd_nor, nd_or, nd_or);

            nor u_nr_nor  (nr_nor, a[gi], b[gi]);
            nor u_nr_or   (nr_or, nr_nor, nr_nor);
            nor u_nr_na   (nr_na, a[gi], a[gi]);
            nor u_nr_nb   (nr_nb, b[gi], b[gi]);
            nor u_nr_and  (nr_and, nr_na, nr_nb);
            nor u_nr_nand (nr_nand, nr_and, nr_and);

            assign nd_y = (op == OP_AND)  ? nd_and  :
                          (op == OP_OR)   ? nd_or   :
                          (op == OP_NAND) ? nd_nand : nd_nor;
            assign nr_y = (op == OP_AND)  ? nr_and  :
                          (op == OP_OR)   ? nr_or   :
                          (op == OP_NAND) ? nr_nand : nr_nor;
            assign y[gi] = (style == STY_NOR) ? nr_y : nd_y;
        end
    endgenerate

endmodule

// File: rtl/demorgan_sweep_checker.sv
// Sweeps all (a,b) pairs, comparing a reference gate against the universal-gate net.
// Optional macro FAULT_INJECT_EN adds fault_on/fault_vec to force a single mismatch.
module demorgan_sweep_checker
    import demorgan_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CW    = 2*WIDTH+1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           op,
    input  logic                 style,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CW-1:0]        mismatch_count,
    output logic [WIDTH-1:0]     first_fail_a,
    output logic [WIDTH-1:0]     first_fail_b,
    output logic                 fail_seen
`ifdef FAULT_INJECT_EN
    ,
    input  logic                 fault_on,
    input  logic [2*WIDTH-1:0]   fault_vec
`endif
);

    localparam int VW = 2*WIDTH;
    localparam logic [VW-1:0] VEC_LAST = '1;
    localparam logic [VW-1:0] VEC_ONE  = VW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e             state_q, state_d;
    logic [VW-1:0]      vec_q, vec_d;
    op_e                op_q, op_d;
    style_e             style_q, style_d;
    logic [CW-1:0]      mcount_q, mcount_d;
    logic [WIDTH-1:0]   ffa_q, ffa_d, ffb_q, ffb_d;
    logic               fail_seen_q, fail_seen_d;
    logic               pass_q, pass_d;

    logic [WIDTH-1:0]   vec_a, vec_b;
    logic [WIDTH-1:0]   ref_y, uni_y, uni_chk;
    logic               vec_fail;
    logic               start_ok;

    assign vec_a = vec_q[VW-1:WIDTH];
    assign vec_b = vec_q[WIDTH-1:0];

    always_comb begin
        ref_y = '0;
        case (op_q)
            OP_AND:  ref_y = vec_a & vec_b;
            OP_OR:   ref_y = vec_a | vec_b;
            OP_NAND: ref_y = ~(vec_a & vec_b);
            OP_NOR:  ref_y = ~(vec_a | vec_b);
            default: ref_y = '0;
        endcase
    end

    universal_gate_net #(.WIDTH(WIDTH)) u_net (
        .a     (vec_a),
        .b     (vec_b),
        .op    (op_q),
        .style (style_q),
        .y     (uni_y)
    );

    always_comb begin
        uni_chk = uni_y;
`ifdef FAULT_INJECT_EN
        uni_chk[0] = uni_y[0] ^ (fault_on && (vec_q == fault_vec));
`endif
    end

    assign vec_fail = |(ref_y ^ uni_chk);
    // abort dominates start in every state
    assign start_ok = start && !abort && (state_q != S_SWEEP);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        op_d        = op_q;
        style_d     = style_q;
        mcount_d    = mcount_q;
        ffa_d       = ffa_q;
        ffb_d       = ffb_q;
        fail_seen_d = fail_seen_q;
        pass_d      = pass_q;
        case (state_q)
            S_IDLE, S_REPORT: begin
                if (start_ok) begin
                    state_d     = S_SWEEP;
                    vec_d       = '0;
                    op_d        = op_e'(op);
                    style_d     = style_e'(style);
                    mcount_d    = '0;
                    ffa_d       = '0;
                    ffb_d       = '0;
                    fail_seen_d = 1'b0;
                    pass_d      = 1'b0;
                end else if (state_q == S_REPORT) begin
                    state_d = S_IDLE;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    if (vec_fail) begin
                        mcount_d = mcount_q + CNT_ONE;
                        if (!fail_seen_q) begin
                            ffa_d       = vec_a;
                            ffb_d       = vec_b;
                            fail_seen_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = S_REPORT;
                        pass_d  = (mcount_d == '0);
                    end else begin
                        vec_d = vec_q + VEC_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            op_q        <= OP_AND;
            style_q     <= STY_NAND;
            mcount_q    <= '0;
            ffa_q       <= '0;
            ffb_q       <= '0;
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            op_q        <= op_d;
            style_q     <= style_d;
            mcount_q    <= mcount_d;
            ffa_q       <= ffa_d;
            ffb_q       <= ffb_d;
            fail_seen_q <= fail_seen_d;
            pass_q      <= pass_d;
        end
    end

    assign busy           = (state_q == S_SWEEP);
    assign done           = (state_q == S_REPORT);
    assign pass           = pass_q;
    assign mismatch_count = mcount_q;
    assign first_fail_a   = ffa_q;
    assign first_fail_b   = ffb_q;
    assign fail_seen      = fail_seen_q;

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Directed bench for demorgan_sweep_checker at WIDTH=2 (16-vector sweeps).
module tb_demorgan_sweep_checker;

    localparam int WIDTH = 2;
    localparam int CW    = 2*WIDTH+1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       op = 2'd0;
    logic             style = 1'b0;
    logic             busy, done, pass, fail_seen;
    logic [CW-1:0]    mismatch_count;
    logic [WIDTH-1:0] first_fail_a, first_fail_b;
`ifdef FAULT_INJECT_EN
    logic             fault_on = 1'b0;
    logic [2*WIDTH-1:0] fault_vec = '0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demorgan_sweep_checker #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .op             (op),
        .style          (style),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_count (mismatch_count),
        .first_fail_a   (first_fail_a),
        .first_fail_b   (first_fail_b),
        .fail_seen      (fail_seen)
`ifdef FAULT_INJECT_EN
        ,
        .fault_on       (fault_on),
        .fault_vec      (fault_vec)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // counts cycles while busy is high, bounded so a stuck DUT cannot hang the run
    task automatic run_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    task automatic issue_start(input logic [1:0] o, input logic s);
        op = o;
        style = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_vec++; if ({busy, done, pass, fail_seen} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, fail_seen}); end
        n_vec++; if (mismatch_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", mismatch_count); end
        n_vec++; if ({first_fail_a, first_fail_b} !== 4'b0000) begin n_bad++; $display("FAIL reset_first_fail: got %b expected 0000", {first_fail_a, first_fail_b}); end
        tick();
        rst = 1'b0;
        tick();
        $display("reset released");
    endtask

    task automatic test_single;
        int cnt;
        issue_start(2'd0, 1'b0);
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
        run_busy(cnt);
        n_vec++; if (cnt != 16) begin n_bad++; $display("FAIL single_busy_len: got %0d expected 16", cnt); end
        n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b expected 1", done); end
        n_vec++; if (pass !== 1'b1) begin n_bad++; $display("FAIL single_pass: got %b expected 1", pass); end
        n_vec++; if (mismatch_count !== '0) begin n_bad++; $display("FAIL single_count: got %0d expected 0", mismatch_count); end
        n_vec++; if (fail_seen !== 1'b0) begin n_bad++; $display("FAIL single_fail_seen: got %b expected 0", fail_seen); end
        tick();
        n_vec++; if ({done, busy, pass} !== 3'b001) begin n_bad++; $display("FAIL single_after_done: done/busy/pass got %b expected 001", {done, busy, pass}); end
        $display("sweep op=AND style=NAND busy_cycles=%0d mismatches=%0d pass=%b", cnt, mismatch_count, pass);
    endtask

    task automatic test_all_ops;
        int cnt;
        int done_cnt;
        logic [2:0] kk;
        done_cnt = 0;
        issue_start(2'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            run_busy(cnt);
            n_vec++; if (cnt != 16) begin n_bad++; $display("FAIL b2b_busy_len[%0d]: got %0d expected 16", k, cnt); end
            n_vec++; if ({done, pass} !== 2'b11) begin n_bad++; $display("FAIL b2b_done_pass[%0d]: got %b expected 11", k, {done, pass}); end
            if (done === 1'b1) done_cnt++;
            $display("sweep op=%0d style=%0d busy_cycles=%0d mismatches=%0d pass=%b", op, style, cnt, mismatch_count, pass);
            if (k < 7) begin
                kk = 3'(k + 1);
                issue_start(kk[1:0], kk[2]);
                n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart[%0d]: busy got %b expected 1", k, busy); end
            end else begin
                tick();
            end
        end
        n_vec++; if (done_cnt != 8) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 8", done_cnt); end
    endtask

    task automatic test_abort;
        logic done_seen;
        issue_start(2'd1, 1'b1);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++; if ({busy, done, pass} !== 3'b000) begin n_bad++; $display("FAIL abort_state: busy/done/pass got %b expected 000", {busy, done, pass}); end
        n_vec++; if (mismatch_count !== '0) begin n_bad++; $display("FAIL abort_count: got %0d expected 0", mismatch_count); end
        done_seen = 1'b0;
        repeat (20) begin
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
            tick();
        end
        n_vec++; if (done_seen !== 1'b0) begin n_bad++; $display("FAIL abort_quiet: activity got %b expected 0", done_seen); end
        $display("abort at sweep cycle 5 busy=%b done=%b pass=%b", busy, done, pass);
    endtask

    task automatic test_start_ignored;
        int cnt;
        issue_start(2'd2, 1'b0);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_busy(cnt);
        n_vec++; if (cnt != 13) begin n_bad++; $display("FAIL busy_start_ignored: remaining busy got %0d expected 13", cnt); end
        n_vec++; if ({done, pass} !== 2'b11) begin n_bad++; $display("FAIL busy_start_done: got %b expected 11", {done, pass}); end
        tick();
        issue_start(2'd3, 1'b1);
        repeat (7) tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_vec++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL start_abort_sweep: busy/done got %b expected 00", {busy, done}); end
        repeat (5) tick();
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_abort_dropped: busy got %b expected 0", busy); end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_abort_idle: busy got %b expected 0", busy); end
        $display("start in sweep ignored, start+abort dropped busy=%b", busy);
    endtask

    task automatic test_async_reset;
        int cnt;
        issue_start(2'd0, 1'b0);
        run_busy(cnt);
        tick();
        n_vec++; if (pass !== 1'b1) begin n_bad++; $display("FAIL pass_held: got %b expected 1", pass); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (pass !== 1'b0) begin n_bad++; $display("FAIL async_rst_pass: got %b expected 0", pass); end
        #2 rst = 1'b0;
        tick();
        issue_start(2'd3, 1'b0);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({busy, done, pass, fail_seen} !== 4'b0000) begin n_bad++; $display("FAIL async_rst_flags: got %b expected 0000", {busy, done, pass, fail_seen}); end
        n_vec++; if ({mismatch_count, first_fail_a, first_fail_b} !== '0) begin n_bad++; $display("FAIL async_rst_regs: got %b expected 0", {mismatch_count, first_fail_a, first_fail_b}); end
        #2 rst = 1'b0;
        tick();
        issue_start(2'd2, 1'b1);
        run_busy(cnt);
        n_vec++; if (cnt != 16) begin n_bad++; $display("FAIL post_rst_busy_len: got %0d expected 16", cnt); end
        n_vec++; if ({done, pass} !== 2'b11) begin n_bad++; $display("FAIL post_rst_done_pass: got %b expected 11", {done, pass}); end
        tick();
        $display("async reset mid-sweep, fresh sweep busy_cycles=%0d", cnt);
    endtask

`ifdef FAULT_INJECT_EN
    task automatic test_fault_inject;
        int cnt;
        fault_on = 1'b1;
        fault_vec = 4'b0110;
        issue_start(2'd0, 1'b0);
        run_busy(cnt);
        n_vec++; if (mismatch_count !== 5'd1) begin n_bad++; $display("FAIL fault_count: got %0d expected 1", mismatch_count); end
        n_vec++; if (first_fail_a !== 2'b01) begin n_bad++; $display("FAIL fault_first_a: got %b expected 01", first_fail_a); end
        n_vec++; if (first_fail_b !== 2'b10) begin n_bad++; $display("FAIL fault_first_b: got %b expected 10", first_fail_b); end
        n_vec++; if ({done, pass, fail_seen} !== 3'b101) begin n_bad++; $display("FAIL fault_flags: done/pass/fail_seen got %b expected 101", {done, pass, fail_seen}); end
        fault_on = 1'b0;
        tick();
        $display("fault sweep mismatches=%0d first=(%b,%b)", mismatch_count, first_fail_a, first_fail_b);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_ops();
        test_abort();
        test_start_ignored();
        test_async_reset();
`ifdef FAULT_INJECT_EN
        test_fault_inject();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
